// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   - sw_state_e : controller FSM state encoding (STOP/RUN/CLEAR)
//   - BTN_*      : bit positions of the buttons inside the 3-bit button vector
//   - div_ratio  : clock-to-tick division ratio helper
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_e;

  localparam int unsigned BTN_RUN   = 0;
  localparam int unsigned BTN_CLEAR = 1;
  localparam int unsigned BTN_ADD   = 2;

  function automatic int unsigned div_ratio(input int unsigned clk_freq,
                                            input int unsigned tick_hz);
    return clk_freq / tick_hz;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/pulse bundle between the stopwatch controller and its environment.
//   btn_run, btn_clear, btn_add : debounced button levels into the controller
//   o_tick, o_clear, o_add      : one-cycle pulses to downstream counters
//   o_run                       : high while the controller is running
// Modports: master = button source / pulse consumer, slave = controller.
interface stopwatch_ctrl_if;
  logic btn_run;
  logic btn_clear;
  logic btn_add;
  logic o_tick;
  logic o_clear;
  logic o_add;
  logic o_run;

  modport master (
    output btn_run, btn_clear, btn_add,
    input  o_tick, o_clear, o_add, o_run
  );

  modport slave (
    input  btn_run, btn_clear, btn_add,
    output o_tick, o_clear, o_add, o_run
  );
endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// tick_gen: free-running divider 0..DIV-1 with a registered wrap pulse.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enable     : count one step per cycle when high, hold otherwise
//   clear      : force the divider to 0 (wins over enable)
//   o_tick     : one-cycle pulse the cycle after the divider wraps DIV-1 -> 0
// Parameter DIV : division ratio, must be >= 2.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic o_tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/clear controller for a stopwatch counter chain.
// Ports:
//   clk   : system clock, all logic on the rising edge
//   reset : synchronous active-high reset
//   bus   : stopwatch_ctrl_if.slave (button levels in, tick/clear/add/run out)
// Parameters: CLK_FREQ (Hz), TICK_HZ (Hz); DIV = CLK_FREQ/TICK_HZ >= 2.
// Build option: define STOPWATCH_BTN_SYNC_EN to pass the buttons through a
// two-flop synchronizer before edge detection (two cycles extra latency).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned TICK_HZ  = 100
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned DIV = div_ratio(CLK_FREQ, TICK_HZ);

  logic [2:0] btn_raw;
  logic [2:0] btn_s;
  logic [2:0] prev_q;
  logic [2:0] rise;

  sw_state_e state_q, state_d;
  logic      add_q, add_d;

  assign btn_raw[BTN_RUN]   = bus.btn_run;
  assign btn_raw[BTN_CLEAR] = bus.btn_clear;
  assign btn_raw[BTN_ADD]   = bus.btn_add;

`ifdef STOPWATCH_BTN_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = btn_raw;
`endif

  // prev_q resets to 0, so a button held through reset release is an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= btn_s;
    end
  end

  assign rise = btn_s & ~prev_q;

  always_comb begin
    state_d = state_q;
    add_d   = 1'b0;
    unique case (state_q)
      ST_STOP: begin
        // Clear beats run; add only fires on an otherwise quiet cycle.
        if (rise[BTN_CLEAR]) begin
          state_d = ST_CLEAR;
        end else if (rise[BTN_RUN]) begin
          state_d = ST_RUN;
        end else if (rise[BTN_ADD]) begin
          add_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (rise[BTN_RUN]) begin
          state_d = ST_STOP;
        end
      end
      ST_CLEAR: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
      add_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      add_q   <= add_d;
    end
  end

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_RUN),
    .clear  (state_q == ST_CLEAR),
    .o_tick (bus.o_tick)
  );

  assign bus.o_run   = (state_q == ST_RUN);
  assign bus.o_clear = (state_q == ST_CLEAR);
  assign bus.o_add   = add_q;

endmodule
